// File: rtl/bit_latch_pkg.sv
// Shared sizing helpers and defaults for the multi-bank addressable bit latch.
package bit_latch_pkg;

  localparam logic DEFAULT_RESET_BIT = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int bank_width(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int bank_base(input int b, input int bw);
    return b * bw;
  endfunction

  // A single bank still needs a 1-bit readback select port.
  function automatic int sel_width(input int banks);
    return (clog2(banks) < 1) ? 1 : clog2(banks);
  endfunction

endpackage

// File: rtl/bit_latch_bank_strobe_filter.sv
// Per-bank strobe conditioning: synchroniser, low-time filter and post-reset arming.
module strobe_filter
  import bit_latch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_n,
  output logic accept
);

  localparam int CW = clog2(MIN_LOW + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   armed_q, armed_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // The reset value of the synchroniser is not a real pad sample; arming waits
  // until the chain has been refilled from the pad so a strobe held low through
  // reset release cannot arm on stale ones.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], strobe_n};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    armed_d = armed_q | (s & fill_q[SYNC_STAGES-1]);
    cnt_d   = cnt_q;
    if (s) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(MIN_LOW)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign accept = armed_q & ~s & (cnt_q == CW'(MIN_LOW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      fill_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/bit_latch_bank.sv
// Multi-bank addressable bit latch with clear/demux mode, write pulses and bit readback.
module bit_latch_bank
  import bit_latch_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int BANKS       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2,
  parameter logic [BANKS*(1<<ADDR_W)-1:0] RESET_VAL =
    {(BANKS*(1<<ADDR_W)){DEFAULT_RESET_BIT}}
) (
  input  logic                            CLK_24M,
  input  logic                            RESET,
  input  logic [ADDR_W-1:0]               ADDR,
  input  logic                            DIN,
  input  logic [BANKS-1:0]                nBITW,
  input  logic [BANKS-1:0]                nCLR,
  input  logic [sel_width(BANKS)-1:0]     RD_BANK,
  output logic [BANKS*(1<<ADDR_W)-1:0]    LATCH,
  output logic [BANKS-1:0]                WR_PULSE,
  output logic                            RDATA
);

  localparam int BW    = bank_width(ADDR_W);
  localparam int TOTAL = BANKS * BW;

  logic [SYNC_STAGES-1:0][BANKS-1:0] clr_sync_q, clr_sync_d;
  logic [TOTAL-1:0]                  latch_q, latch_d;
  logic [BANKS-1:0]                  wr_pulse_q, wr_pulse_d;
  logic [BANKS-1:0]                  accept, clr;
  logic [BW-1:0]                     bit_sel, bank;
  logic [TOTAL-1:0]                  rd_shift;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    strobe_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .MIN_LOW    (MIN_LOW)
    ) u_filt (
      .clk     (CLK_24M),
      .rst     (RESET),
      .strobe_n(nBITW[b]),
      .accept  (accept[b])
    );
  end

  assign clr     = ~clr_sync_q[SYNC_STAGES-1];
  assign bit_sel = BW'(1) << ADDR;

  // Clear is applied first so an accept in the same cycle leaves only the
  // addressed bit, giving the 259 demux behaviour.
  always_comb begin
    clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], nCLR};
    wr_pulse_d = accept;
    latch_d    = latch_q;
    bank       = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank = latch_q[bank_base(b, BW) +: BW];
      if (clr[b]) bank = '0;
      if (accept[b]) bank = (bank & ~bit_sel) | (DIN ? bit_sel : '0);
      latch_d[bank_base(b, BW) +: BW] = bank;
    end
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      clr_sync_q <= '1;
      latch_q    <= RESET_VAL;
      wr_pulse_q <= '0;
    end else begin
      clr_sync_q <= clr_sync_d;
      latch_q    <= latch_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Bank width is a power of two, so {RD_BANK, ADDR} is the flat bit index.
  assign rd_shift = latch_q >> {RD_BANK, ADDR};
  assign RDATA    = (int'(RD_BANK) < BANKS) ? rd_shift[0] : 1'b0;

  assign LATCH    = latch_q;
  assign WR_PULSE = wr_pulse_q;

endmodule

// File: tb/tb_bit_latch_bank.sv
// Scoreboard bench for bit_latch_bank: stimulus queues expected writes, a monitor checks each WR_PULSE.
module tb_bit_latch_bank;

  localparam int           LAT = 4;   // drive-to-update: SYNC_STAGES + MIN_LOW posedges
  localparam logic [15:0]  RV  = 16'h00A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = '0;
  logic        din = 1'b0;
  logic [1:0]  nbitw = 2'b11;
  logic [1:0]  nclr = 2'b11;
  logic [0:0]  rd_bank = '0;
  logic [15:0] latch;
  logic [1:0]  wr_pulse;
  logic        rdata;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model;

  typedef struct {
    logic [1:0]  pulse;
    logic [15:0] latch;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  bit_latch_bank #(
    .ADDR_W(3), .BANKS(2), .SYNC_STAGES(2), .MIN_LOW(2), .RESET_VAL(RV)
  ) dut (
    .CLK_24M (clk),
    .RESET   (rst),
    .ADDR    (addr),
    .DIN     (din),
    .nBITW   (nbitw),
    .nCLR    (nclr),
    .RD_BANK (rd_bank),
    .LATCH   (latch),
    .WR_PULSE(wr_pulse),
    .RDATA   (rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every WR_PULSE consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_pulse != 2'b00) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got WR_PULSE=%b LATCH=%h, expected no pulse", wr_pulse, latch);
        end else begin
          e = sb_q.pop_front();
          check("pulse_mask", 32'(wr_pulse), 32'(e.pulse));
          check("pulse_latch", 32'(latch), 32'(e.latch));
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Called at a negedge; drives strobes/clears for the given masks and lengths.
  task automatic access(input logic [1:0] mask, input logic [2:0] a, input logic d,
                        input int low, input int clr_len, input bit expect_wr,
                        input logic [15:0] exp_latch);
    exp_t e;
    addr = a;
    din  = d;
    if (expect_wr) begin
      e.pulse = mask;
      e.latch = exp_latch;
      e.cyc   = cyc + LAT;
      sb_q.push_back(e);
    end
    for (int i = 0; i < ((low > clr_len) ? low : clr_len); i++) begin
      nbitw = (i < low)     ? ~mask : 2'b11;
      nclr  = (i < clr_len) ? ~mask : 2'b11;
      @(negedge clk);
    end
    nbitw = 2'b11;
    nclr  = 2'b11;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset value, during and after reset
    repeat (2) @(negedge clk);
    check("reset_latch", 32'(latch), 32'(RV));
    check("reset_pulse", 32'(wr_pulse), 32'h0);
    check("reset_rdata", 32'(rdata), 32'h1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset_latch", 32'(latch), 32'(RV));
    addr = 3'd2;
    #1 check("rdata_b0_a2", 32'(rdata), 32'h1);
    rd_bank = 1'b1;
    addr = 3'd0;
    #1 check("rdata_b1_a0", 32'(rdata), 32'h0);
    rd_bank = 1'b0;

    // clear both banks to get a zero starting point
    nclr = 2'b00;
    repeat (4) @(negedge clk);
    nclr = 2'b11;
    repeat (4) @(negedge clk);
    check("clear_all", 32'(latch), 32'h0);

    // 2. single-bank writes, long strobe gives one write only
    access(2'b01, 3'd7, 1'b1, 4, 0, 1'b1, 16'h0080);
    access(2'b10, 3'd0, 1'b1, 10, 0, 1'b1, 16'h0180);
    addr = 3'd7;
    #1 check("rdata_b0_a7", 32'(rdata), 32'h1);

    // 3. glitch filter boundary
    access(2'b01, 3'd2, 1'b1, 1, 0, 1'b0, 16'h0000);
    check("glitch_1cyc", 32'(latch), 32'h0180);
    access(2'b01, 3'd2, 1'b1, 2, 0, 1'b1, 16'h0184);

    // 4. fill to all ones, then clear bank 1, then demux bank 0
    model = 16'h0184;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        model = model | (16'h0001 << (b * 8 + i));
        access(2'(1 << b), 3'(i), 1'b1, 3, 0, 1'b1, model);
      end
    end
    check("fill_all", 32'(latch), 32'hFFFF);
    nclr = 2'b01;
    repeat (2) @(negedge clk);
    check("clr_edge1", 32'(latch), 32'hFFFF);
    @(negedge clk);
    check("clr_edge2", 32'(latch), 32'h00FF);
    repeat (2) @(negedge clk);
    nclr = 2'b11;
    repeat (4) @(negedge clk);
    check("clr_hold", 32'(latch), 32'h00FF);
    access(2'b01, 3'd3, 1'b1, 4, 2, 1'b1, 16'h0008);
    check("demux_final", 32'(latch), 32'h0008);

    // 5. reset in the middle of a strobe
    addr  = 3'd1;
    din   = 1'b1;
    nbitw = 2'b10;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_mid_strobe", 32'(latch), 32'(RV));
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("unarmed_no_write", 32'(latch), 32'(RV));
    nbitw = 2'b11;
    @(negedge clk);
    access(2'b01, 3'd1, 1'b1, 3, 0, 1'b1, 16'h00A7);

    // 6. simultaneous writes on both banks
    access(2'b11, 3'd5, 1'b1, 3, 0, 1'b1, 16'h20A7);
    rd_bank = 1'b1;
    addr = 3'd5;
    #1 check("rdata_b1_a5", 32'(rdata), 32'h1);
    addr = 3'd4;
    #1 check("rdata_b1_a4", 32'(rdata), 32'h0);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
